// File: rtl/fifo_pkt_tx.sv
// Framed byte transmitter: drains 33-bit FIFO words ({eop, payload}) and emits a start-of-frame
// byte per packet followed by each payload word little-endian on an 8-bit valid/ready link.
module fifo_pkt_tx #(
  parameter logic [7:0]  SOF_BYTE = 8'h7E,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             upstr_d_valid,
  input  logic [32:0]      upstr_data,
  output logic             upstr_d_ready,
  output logic             downstr_d_valid,
  output logic [7:0]       downstr_data,
  output logic             downstr_last,
  input  logic             downstr_d_ready,
  output logic [CNT_W-1:0] pkt_cnt
);

  typedef enum logic [1:0] {StIdle, StSof, StBytes, StWait} state_e;

  state_e           state_q, state_d;
  logic [32:0]      word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             word_acc, byte_acc;

  assign pkt_cnt = cnt_q;

  // Outputs depend only on registers, except ready on the final byte of a non-last word.
  always_comb begin
    upstr_d_ready   = 1'b0;
    downstr_d_valid = 1'b0;
    downstr_data    = 8'h00;
    downstr_last    = 1'b0;
    unique case (state_q)
      StIdle, StWait: upstr_d_ready = 1'b1;
      StSof: begin
        downstr_d_valid = 1'b1;
        downstr_data    = SOF_BYTE;
      end
      StBytes: begin
        downstr_d_valid = 1'b1;
        unique case (idx_q)
          2'd0: downstr_data = word_q[7:0];
          2'd1: downstr_data = word_q[15:8];
          2'd2: downstr_data = word_q[23:16];
          2'd3: downstr_data = word_q[31:24];
          default: downstr_data = 8'h00;
        endcase
        if (idx_q == 2'd3) begin
          downstr_last  = word_q[32];
          upstr_d_ready = downstr_d_ready & ~word_q[32];
        end
      end
      default: ;
    endcase
  end

  assign word_acc = upstr_d_valid & upstr_d_ready;
  assign byte_acc = downstr_d_valid & downstr_d_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (word_acc) begin
          word_d  = upstr_data;
          state_d = StSof;
        end
      end
      StSof: begin
        if (byte_acc) begin
          idx_d   = 2'd0;
          state_d = StBytes;
        end
      end
      StBytes: begin
        if (byte_acc) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else if (word_q[32]) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = StIdle;
          end else if (word_acc) begin
            // Next word of the same packet arrived in time: continue without a bubble.
            word_d = upstr_data;
            idx_d  = 2'd0;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (word_acc) begin
          word_d  = upstr_data;
          idx_d   = 2'd0;
          state_d = StBytes;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_pkt_tx.sv
// Directed bench for fifo_pkt_tx; a second instance with a 2-bit counter shares the stimulus
// so counter wrap-around can be observed alongside the default configuration.
module tb_fifo_pkt_tx;

  logic        clk;
  logic        nrst;
  logic        us_valid;
  logic [32:0] us_data;
  logic        us_ready;
  logic        ds_valid;
  logic [7:0]  ds_data;
  logic        ds_last;
  logic        ds_ready;
  logic [15:0] cnt;

  logic        us_ready2;
  logic        ds_valid2;
  logic [7:0]  ds_data2;
  logic        ds_last2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  fifo_pkt_tx u_dut (
    .clk             (clk),
    .nrst            (nrst),
    .upstr_d_valid   (us_valid),
    .upstr_data      (us_data),
    .upstr_d_ready   (us_ready),
    .downstr_d_valid (ds_valid),
    .downstr_data    (ds_data),
    .downstr_last    (ds_last),
    .downstr_d_ready (ds_ready),
    .pkt_cnt         (cnt)
  );

  fifo_pkt_tx #(.CNT_W(2)) u_dut2 (
    .clk             (clk),
    .nrst            (nrst),
    .upstr_d_valid   (us_valid),
    .upstr_data      (us_data),
    .upstr_d_ready   (us_ready2),
    .downstr_d_valid (ds_valid2),
    .downstr_data    (ds_data2),
    .downstr_last    (ds_last2),
    .downstr_d_ready (ds_ready),
    .pkt_cnt         (cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_byte(input string tag, input logic [7:0] d, input logic l, input logic rdy);
    #1;
    chk({tag, "_valid"}, 32'(ds_valid), 32'd1);
    chk({tag, "_data"}, 32'(ds_data), 32'(d));
    chk({tag, "_last"}, 32'(ds_last), 32'(l));
    chk({tag, "_uready"}, 32'(us_ready), 32'(rdy));
  endtask

  task automatic exp_gap(input string tag);
    #1;
    chk({tag, "_valid"}, 32'(ds_valid), 32'd0);
    chk({tag, "_uready"}, 32'(us_ready), 32'd1);
  endtask

  // Four payload bytes of one word with the sink always ready.
  task automatic bytes_of(input string tag, input logic [31:0] w, input logic last);
    for (int i = 0; i < 4; i++) begin
      exp_byte(tag, w[8*i +: 8], last && (i == 3), !last && (i == 3));
      tick();
    end
  endtask

  logic       rdy_seq  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] data_seq [10] = '{8'h7E, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h33, 8'h33,
                                8'h44, 8'h44};
  logic       last_seq [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    nrst     = 1'b0;
    us_valid = 1'b0;
    us_data  = '0;
    ds_ready = 1'b0;
    #12;
    chk("rst_uready", 32'(us_ready), 32'd1);
    chk("rst_valid", 32'(ds_valid), 32'd0);
    chk("rst_data", 32'(ds_data), 32'd0);
    chk("rst_last", 32'(ds_last), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    nrst = 1'b1;
    tick();

    // Single-word packet, sink always ready.
    ds_ready = 1'b1;
    us_valid = 1'b1;
    us_data  = {1'b1, 32'hDDCCBBAA};
    #1 chk("t1_idle_uready", 32'(us_ready), 32'd1);
    tick();
    us_valid = 1'b0;
    exp_byte("t1_sof", 8'h7E, 1'b0, 1'b0);
    tick();
    bytes_of("t1", 32'hDDCCBBAA, 1'b1);
    exp_gap("t1_done");
    chk("t1_cnt", 32'(cnt), 32'd1);

    // Two-word packet, back-to-back.
    us_valid = 1'b1;
    us_data  = {1'b0, 32'h04030201};
    tick();
    us_data = {1'b1, 32'h08070605};
    exp_byte("t2_sof", 8'h7E, 1'b0, 1'b0);
    tick();
    bytes_of("t2_w0", 32'h04030201, 1'b0);
    us_valid = 1'b0;
    bytes_of("t2_w1", 32'h08070605, 1'b1);
    exp_gap("t2_done");
    chk("t2_cnt", 32'(cnt), 32'd2);

    // Two-word packet, second word late: WAIT, then no second SOF.
    us_valid = 1'b1;
    us_data  = {1'b0, 32'h04030201};
    tick();
    us_valid = 1'b0;
    exp_byte("t3_sof", 8'h7E, 1'b0, 1'b0);
    tick();
    bytes_of("t3_w0", 32'h04030201, 1'b0);
    exp_gap("t3_wait1");
    tick();
    exp_gap("t3_wait2");
    tick();
    us_valid = 1'b1;
    us_data  = {1'b1, 32'h08070605};
    exp_gap("t3_wait3");
    tick();
    us_valid = 1'b0;
    bytes_of("t3_w1", 32'h08070605, 1'b1);
    exp_gap("t3_done");
    chk("t3_cnt", 32'(cnt), 32'd3);

    // Sink stalls: data/last held, nothing dropped or duplicated, ready stays low.
    ds_ready = 1'b0;
    us_valid = 1'b1;
    us_data  = {1'b1, 32'h44332211};
    tick();
    us_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ds_ready = rdy_seq[i];
      exp_byte("t4_stall", data_seq[i], last_seq[i], 1'b0);
      tick();
    end
    ds_ready = 1'b1;
    exp_gap("t4_done");
    chk("t4_cnt", 32'(cnt), 32'd4);
    chk("t4_cnt2_wrap", 32'(cnt2), 32'd0);

    // Clean reset, then reset mid-word at byte_idx 2.
    nrst = 1'b0;
    #1 chk("t6_pre_cnt", 32'(cnt), 32'd0);
    nrst = 1'b1;
    tick();
    us_valid = 1'b1;
    us_data  = {1'b1, 32'hA1B2C3D4};
    tick();
    us_valid = 1'b0;
    exp_byte("t6_sof", 8'h7E, 1'b0, 1'b0);
    tick();
    exp_byte("t6_b0", 8'hD4, 1'b0, 1'b0);
    tick();
    exp_byte("t6_b1", 8'hC3, 1'b0, 1'b0);
    tick();
    ds_ready = 1'b0;
    exp_byte("t6_b2", 8'hB2, 1'b0, 1'b0);
    nrst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(ds_valid), 32'd0);
    chk("t6_rst_uready", 32'(us_ready), 32'd1);
    chk("t6_rst_data", 32'(ds_data), 32'd0);
    chk("t6_rst_last", 32'(ds_last), 32'd0);
    chk("t6_rst_cnt", 32'(cnt), 32'd0);
    tick();
    nrst     = 1'b1;
    ds_ready = 1'b1;
    us_valid = 1'b1;
    us_data  = {1'b1, 32'h5A5A5A7E};
    tick();
    us_valid = 1'b0;
    exp_byte("t6_next_sof", 8'h7E, 1'b0, 1'b0);
    tick();
    bytes_of("t6_next", 32'h5A5A5A7E, 1'b1);
    exp_gap("t6_done");
    chk("t6_cnt", 32'(cnt), 32'd1);

    // Five single-word packets with upstream valid held high.
    us_valid = 1'b1;
    for (int p = 0; p < 5; p++) begin
      us_data = {1'b1, 32'h10203040 + 32'(p)};
      exp_gap("t5_idle");
      tick();
      exp_byte("t5_sof", 8'h7E, 1'b0, 1'b0);
      tick();
      bytes_of("t5", 32'h10203040 + 32'(p), 1'b1);
      chk("t5_cnt", 32'(cnt), 32'(p + 2));
      chk("t5_cnt2", 32'(cnt2), 32'((p + 2) % 4));
    end
    us_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
